// File: rtl/pong_match_ctrl_if.sv
// Match-controller signal bundle: inputs from the frame timer, buttons and ball, and controls back to the ball and the HUD.
// Latency: none (wires only).
// Backpressure: none; all signals are strobes or levels.
// Ports: master = environment side (drives the in_* signals); slave = controller side (drives the out_* signals).
interface pong_match_ctrl_if;
    logic       in_frame_stb;
    logic       in_start_btn;
    logic       in_pause_btn;
    logic       in_left_score;
    logic       in_right_score;
    logic       out_ball_reset;
    logic       out_ball_start;
    logic       out_animate;
    logic [3:0] out_left_points;
    logic [3:0] out_right_points;
    logic [1:0] out_winner;
    logic [2:0] out_state;

    modport master (
        output in_frame_stb, in_start_btn, in_pause_btn, in_left_score, in_right_score,
        input  out_ball_reset, out_ball_start, out_animate,
        input  out_left_points, out_right_points, out_winner, out_state
    );

    modport slave (
        input  in_frame_stb, in_start_btn, in_pause_btn, in_left_score, in_right_score,
        output out_ball_reset, out_ball_start, out_animate,
        output out_left_points, out_right_points, out_winner, out_state
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, point counting, winner detection, ball reset/start/animate control.
// Latency: button action 3 cycles after the pin rises (action on the 4th edge); score edge acts on the same edge; pulses are registered.
// Backpressure: none; strobes and levels only, and one action per button press.
// Ports: in_clock, in_reset (async, active-high); bus (slave modport) carries frame strobe, buttons, score flags and all outputs.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic              in_clock,
    input  logic              in_reset,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_POINT  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [3:0] WIN_PTS   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_CNT = 8'(SERVE_DELAY);

    // Button synchronizers: [0],[1] are the 2-flop synchronizer, [2] holds the previous synced value.
    logic [2:0] start_sync_q;
    logic [2:0] pause_sync_q;
    logic       start_edge_q;
    logic       pause_edge_q;
    logic       left_prev_q;
    logic       right_prev_q;

    state_t     state_q,  state_d;
    logic [7:0] cnt_q,    cnt_d;
    logic [3:0] left_q,   left_d;
    logic [3:0] right_q,  right_d;
    logic [1:0] winner_q, winner_d;
    logic       ball_reset_q, ball_reset_d;
    logic       ball_start_q, ball_start_d;

    logic       left_edge;
    logic       right_edge;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            start_sync_q <= '0;
            pause_sync_q <= '0;
            start_edge_q <= 1'b0;
            pause_edge_q <= 1'b0;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], bus.in_start_btn};
            pause_sync_q <= {pause_sync_q[1:0], bus.in_pause_btn};
            start_edge_q <= start_sync_q[1] & ~start_sync_q[2];
            pause_edge_q <= pause_sync_q[1] & ~pause_sync_q[2];
            left_prev_q  <= bus.in_left_score;
            right_prev_q <= bus.in_right_score;
        end
    end

    // Score flags are already in this clock domain, so only an edge detect is needed.
    assign left_edge  = bus.in_left_score  & ~left_prev_q;
    assign right_edge = bus.in_right_score & ~right_prev_q;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            winner_q     <= 2'b00;
            ball_reset_q <= 1'b0;
            ball_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            left_q       <= left_d;
            right_q      <= right_d;
            winner_q     <= winner_d;
            ball_reset_q <= ball_reset_d;
            ball_start_q <= ball_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        left_d       = left_q;
        right_d      = right_q;
        winner_d     = winner_q;
        ball_reset_d = 1'b0;
        ball_start_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge_q) begin
                    left_d       = '0;
                    right_d      = '0;
                    winner_d     = 2'b00;
                    ball_reset_d = 1'b1;
                    cnt_d        = SERVE_CNT;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (bus.in_frame_stb) begin
                    // The reset pulse occupies the first SERVE cycle, so a start
                    // pulse issued here can never overlap it.
                    if (cnt_q <= 8'd1) begin
                        cnt_d        = '0;
                        ball_start_d = 1'b1;
                        state_d      = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (left_edge || right_edge) begin
                    // Saturate at the winning score; the game ends there anyway.
                    if (left_edge && (left_q < WIN_PTS)) begin
                        left_d = left_q + 4'd1;
                    end
                    if (right_edge && (right_q < WIN_PTS)) begin
                        right_d = right_q + 4'd1;
                    end
                    state_d = ST_POINT;
                end else if (pause_edge_q) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_edge_q) begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                // Left is checked first so a simultaneous double win goes to left.
                if (left_q == WIN_PTS) begin
                    winner_d = 2'b01;
                    state_d  = ST_OVER;
                end else if (right_q == WIN_PTS) begin
                    winner_d = 2'b10;
                    state_d  = ST_OVER;
                end else begin
                    cnt_d   = SERVE_CNT;
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_ball_reset   = ball_reset_q;
    assign bus.out_ball_start   = ball_start_q;
    assign bus.out_animate      = (state_q == ST_SERVE) || (state_q == ST_PLAY);
    assign bus.out_left_points  = left_q;
    assign bus.out_right_points = right_q;
    assign bus.out_winner       = winner_q;
    assign bus.out_state        = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl (WIN_SCORE=2, SERVE_DELAY=3).
// Latency: inputs are driven 1 ns after posedge; outputs are sampled 1 ns after the following posedge.
// Backpressure: none; the bench drives strobes and levels only.
module tb_pong_match_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pong_match_ctrl_if bus();

    pong_match_ctrl #(.WIN_SCORE(2), .SERVE_DELAY(3)) dut (
        .in_clock (clk),
        .in_reset (rst),
        .bus      (bus)
    );

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSED = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       f, l, r;
        logic [2:0] st;
        logic [3:0] lp, rp;
        logic [1:0] win;
        logic       anim, bst, brs;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic f, l, r, input logic [2:0] st,
                                input logic [3:0] lp, rp, input logic [1:0] win,
                                input logic anim, bst, brs);
        vec_t v;
        v.f = f; v.l = l; v.r = r; v.st = st; v.lp = lp; v.rp = rp;
        v.win = win; v.anim = anim; v.bst = bst; v.brs = brs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a button high for three edges; the action lands on the next edge.
    task automatic press(input bit pause);
        if (pause) bus.in_pause_btn = 1'b1; else bus.in_start_btn = 1'b1;
        repeat (3) tick();
        bus.in_pause_btn = 1'b0;
        bus.in_start_btn = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] exp, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.out_state == exp) break;
        end
        chk(name, 32'(bus.out_state), 32'(exp));
    endtask

    task automatic start_game(input string name);
        bit got;
        press(1'b0);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_ball_reset) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_reset_pulse"}, 32'(got), 32'd1);
        chk({name, "_state"}, 32'(bus.out_state), 32'(S_SERVE));
        chk({name, "_anim"}, 32'(bus.out_animate), 32'd1);
        chk({name, "_pts"}, 32'({bus.out_left_points, bus.out_right_points}), 32'd0);
        chk({name, "_winner"}, 32'(bus.out_winner), 32'd0);
        chk({name, "_start_low"}, 32'(bus.out_ball_start), 32'd0);
        tick();
        chk({name, "_reset_1cyc"}, 32'(bus.out_ball_reset), 32'd0);
    endtask

    // Three frame strobes: ball_start must appear only after the third.
    task automatic serve(input string name);
        for (int i = 0; i < 3; i++) begin
            bus.in_frame_stb = 1'b1;
            tick();
            bus.in_frame_stb = 1'b0;
            chk($sformatf("%s_bstart%0d", name, i), 32'(bus.out_ball_start), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("%s_state%0d", name, i), 32'(bus.out_state), (i == 2) ? 32'(S_PLAY) : 32'(S_SERVE));
            if (i < 2) tick();
        end
        chk({name, "_anim"}, 32'(bus.out_animate), 32'd1);
        tick();
        chk({name, "_bstart_1cyc"}, 32'(bus.out_ball_start), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  ok;

        //              f  l  r  state     lp rp win anim bst brs
        tbl[0]  = mk(0, 0, 1, S_POINT, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, S_SERVE, 0, 1, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 1, S_SERVE, 0, 1, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, S_SERVE, 0, 1, 0, 1, 0, 0);
        tbl[4]  = mk(1, 0, 1, S_SERVE, 0, 1, 0, 1, 0, 0);
        tbl[5]  = mk(1, 0, 1, S_PLAY,  0, 1, 0, 1, 1, 0);
        tbl[6]  = mk(0, 0, 1, S_PLAY,  0, 1, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, S_PLAY,  0, 1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, S_POINT, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, S_SERVE, 1, 1, 0, 1, 0, 0);
        tbl[10] = mk(1, 0, 0, S_SERVE, 1, 1, 0, 1, 0, 0);
        tbl[11] = mk(1, 0, 0, S_SERVE, 1, 1, 0, 1, 0, 0);
        tbl[12] = mk(1, 0, 0, S_PLAY,  1, 1, 0, 1, 1, 0);
        tbl[13] = mk(0, 0, 0, S_PLAY,  1, 1, 0, 1, 0, 0);
        tbl[14] = mk(0, 1, 1, S_POINT, 2, 2, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 1, S_OVER,  2, 2, 1, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, S_OVER,  2, 2, 1, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, S_OVER,  2, 2, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0, S_OVER,  2, 2, 1, 0, 0, 0);

        bus.in_frame_stb = 1'b0; bus.in_start_btn = 1'b0; bus.in_pause_btn = 1'b0;
        bus.in_left_score = 1'b0; bus.in_right_score = 1'b0;
        #2 rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_state",  32'(bus.out_state), 32'(S_IDLE));
        chk("rst_points", 32'({bus.out_left_points, bus.out_right_points}), 32'd0);
        chk("rst_winner", 32'(bus.out_winner), 32'd0);
        chk("rst_anim",   32'(bus.out_animate), 32'd0);
        chk("rst_pulses", 32'({bus.out_ball_reset, bus.out_ball_start}), 32'd0);

        start_game("start1");

        // Pause is ignored during the serve countdown.
        press(1'b1);
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (bus.out_state != S_SERVE) ok = 1'b0;
        end
        chk("pause_in_serve_ignored", 32'(ok), 32'd1);
        serve("serve1");

        // Pause and resume in PLAY; strobes while paused do nothing.
        press(1'b1);
        wait_state(S_PAUSED, 6, "pause_enter");
        chk("paused_anim", 32'(bus.out_animate), 32'd0);
        repeat (3) begin
            bus.in_frame_stb = 1'b1; tick();
            bus.in_frame_stb = 1'b0; tick();
        end
        chk("paused_hold_state", 32'(bus.out_state), 32'(S_PAUSED));
        chk("paused_no_start",   32'(bus.out_ball_start), 32'd0);
        press(1'b1);
        wait_state(S_PLAY, 6, "pause_exit");
        chk("resume_anim", 32'(bus.out_animate), 32'd1);

        // Scoring, held score level, simultaneous score to 2-2, game over.
        for (int i = 0; i < 19; i++) begin
            bus.in_frame_stb   = tbl[i].f;
            bus.in_left_score  = tbl[i].l;
            bus.in_right_score = tbl[i].r;
            tick();
            chk($sformatf("vec%0d_state", i),  32'(bus.out_state),        32'(tbl[i].st));
            chk($sformatf("vec%0d_lpts", i),   32'(bus.out_left_points),  32'(tbl[i].lp));
            chk($sformatf("vec%0d_rpts", i),   32'(bus.out_right_points), 32'(tbl[i].rp));
            chk($sformatf("vec%0d_winner", i), 32'(bus.out_winner),       32'(tbl[i].win));
            chk($sformatf("vec%0d_anim", i),   32'(bus.out_animate),      32'(tbl[i].anim));
            chk($sformatf("vec%0d_bstart", i), 32'(bus.out_ball_start),   32'(tbl[i].bst));
            chk($sformatf("vec%0d_breset", i), 32'(bus.out_ball_reset),   32'(tbl[i].brs));
        end
        bus.in_frame_stb = 1'b0; bus.in_left_score = 1'b0; bus.in_right_score = 1'b0;

        // Restart from OVER clears points and winner.
        start_game("restart");
        serve("serve_r");
        bus.in_right_score = 1'b1; tick(); tick();
        bus.in_right_score = 1'b0;
        chk("r_point_state", 32'(bus.out_state), 32'(S_SERVE));
        serve("serve_r2");
        chk("r_point_rpts", 32'(bus.out_right_points), 32'd1);

        // Asynchronous reset between clock edges mid-PLAY.
        #2 rst = 1'b1;
        #1;
        chk("arst_state",  32'(bus.out_state), 32'(S_IDLE));
        chk("arst_rpts",   32'(bus.out_right_points), 32'd0);
        chk("arst_anim",   32'(bus.out_animate), 32'd0);
        chk("arst_pulses", 32'({bus.out_ball_reset, bus.out_ball_start}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Bouncing start button within one cycle on press and release: one action only.
        bus.in_start_btn = 1'b1; #1 bus.in_start_btn = 1'b0; #1 bus.in_start_btn = 1'b1;
        #1 bus.in_start_btn = 1'b0; #1 bus.in_start_btn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_ball_reset) cnt++;
            if (i == 3) begin
                bus.in_start_btn = 1'b0; #1 bus.in_start_btn = 1'b1; #1 bus.in_start_btn = 1'b0;
                #1 bus.in_start_btn = 1'b1; #1 bus.in_start_btn = 1'b0;
            end
        end
        chk("bounce_one_action", 32'(cnt), 32'd1);
        chk("bounce_state", 32'(bus.out_state), 32'(S_SERVE));

        // Left wins 2-0.
        serve("serve_w1");
        bus.in_left_score = 1'b1; tick();
        chk("w1_point", 32'(bus.out_state), 32'(S_POINT));
        chk("w1_lpts",  32'(bus.out_left_points), 32'd1);
        tick();
        bus.in_left_score = 1'b0;
        serve("serve_w2");
        bus.in_left_score = 1'b1; tick(); tick();
        bus.in_left_score = 1'b0;
        chk("win_state",  32'(bus.out_state), 32'(S_OVER));
        chk("win_lpts",   32'(bus.out_left_points), 32'd2);
        chk("win_rpts",   32'(bus.out_right_points), 32'd0);
        chk("win_winner", 32'(bus.out_winner), 32'd1);
        chk("win_anim",   32'(bus.out_animate), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
